// File: rtl/wb_writeback.sv
// Write-back stage: accepts retiring instructions from MEM, waits on and formats
// load data, and drives the register-file write port plus a retired-instruction count.
module wb_writeback #(
  parameter int GPR_ADDR_SPACE = 5,
  parameter int GPR_WIDTH      = 32,
  parameter int CNT_W          = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [GPR_ADDR_SPACE-1:0] rd_addr_i,
  input  logic                      rd_we_i,
  input  logic [GPR_WIDTH-1:0]      alu_val_i,
  input  logic                      is_load_i,
  input  logic [1:0]                load_size_i,
  input  logic                      load_unsigned_i,
  input  logic [1:0]                addr_lo_i,
  input  logic                      dmem_rvalid_i,
  input  logic [GPR_WIDTH-1:0]      dmem_rdata_i,
  input  logic                      flush_i,
  output logic [GPR_ADDR_SPACE-1:0] rd_addr_o,
  output logic [GPR_WIDTH-1:0]      rd_val_o,
  output logic                      rd_we_o,
  output logic [CNT_W-1:0]          retire_cnt_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                    state_q, state_d;
  logic [GPR_ADDR_SPACE-1:0] pend_addr_q, pend_addr_d;
  logic                      pend_we_q, pend_we_d;
  logic [1:0]                pend_size_q, pend_size_d;
  logic                      pend_uns_q, pend_uns_d;
  logic [1:0]                pend_lo_q, pend_lo_d;
  logic [GPR_ADDR_SPACE-1:0] rd_addr_q, rd_addr_d;
  logic [GPR_WIDTH-1:0]      rd_val_q, rd_val_d;
  logic                      rd_we_q, rd_we_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [GPR_WIDTH-1:0]      load_val;

  assign ready_o      = (state_q == IDLE);
  assign rd_addr_o    = rd_addr_q;
  assign rd_val_o     = rd_val_q;
  assign rd_we_o      = rd_we_q;
  assign retire_cnt_o = cnt_q;

  // Lane select uses the latched address bits; halfword ignores addr_lo[0].
  always_comb begin
    byte_sel = dmem_rdata_i[{pend_lo_q, 3'b000} +: 8];
    half_sel = dmem_rdata_i[{pend_lo_q[1], 4'b0000} +: 16];
    case (pend_size_q)
      2'b00:   load_val = {{(GPR_WIDTH-8){~pend_uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{(GPR_WIDTH-16){~pend_uns_q & half_sel[15]}}, half_sel};
      default: load_val = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_we_d   = pend_we_q;
    pend_size_d = pend_size_q;
    pend_uns_d  = pend_uns_q;
    pend_lo_d   = pend_lo_q;
    rd_addr_d   = rd_addr_q;
    rd_val_d    = rd_val_q;
    rd_we_d     = 1'b0;
    cnt_d       = cnt_q;

    if (flush_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (valid_i) begin
        if (is_load_i) begin
          state_d     = WAIT;
          pend_addr_d = rd_addr_i;
          pend_we_d   = rd_we_i;
          pend_size_d = load_size_i;
          pend_uns_d  = load_unsigned_i;
          pend_lo_d   = addr_lo_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Address/value only move on a real write so they hold otherwise.
          if (rd_we_i && (rd_addr_i != '0)) begin
            rd_we_d   = 1'b1;
            rd_addr_d = rd_addr_i;
            rd_val_d  = alu_val_i;
          end
        end
      end
    end else if (dmem_rvalid_i) begin
      state_d = IDLE;
      cnt_d   = cnt_q + CNT_W'(1);
      if (pend_we_q && (pend_addr_q != '0)) begin
        rd_we_d   = 1'b1;
        rd_addr_d = pend_addr_q;
        rd_val_d  = load_val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_we_q   <= 1'b0;
      pend_size_q <= 2'b00;
      pend_uns_q  <= 1'b0;
      pend_lo_q   <= 2'b00;
      rd_addr_q   <= '0;
      rd_val_q    <= '0;
      rd_we_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_we_q   <= pend_we_d;
      pend_size_q <= pend_size_d;
      pend_uns_q  <= pend_uns_d;
      pend_lo_q   <= pend_lo_d;
      rd_addr_q   <= rd_addr_d;
      rd_val_q    <= rd_val_d;
      rd_we_q     <= rd_we_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Bench for wb_writeback: directed vector table, reset-mid-load sequence, then
// random traffic against a behavioural model; a 4-bit-counter instance checks wrap.
module tb_wb_writeback;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o, ready_s;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic [31:0] alu_val_i = '0;
  logic        is_load_i = 1'b0;
  logic [1:0]  load_size_i = '0;
  logic        load_unsigned_i = 1'b0;
  logic [1:0]  addr_lo_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  rd_addr_o, rd_addr_s;
  logic [31:0] rd_val_o, rd_val_s;
  logic        rd_we_o, rd_we_s;
  logic [31:0] retire_cnt_o;
  logic [3:0]  retire_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_writeback #(.GPR_ADDR_SPACE(5), .GPR_WIDTH(32), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .alu_val_i(alu_val_i),
    .is_load_i(is_load_i), .load_size_i(load_size_i), .load_unsigned_i(load_unsigned_i),
    .addr_lo_i(addr_lo_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .flush_i(flush_i), .rd_addr_o(rd_addr_o), .rd_val_o(rd_val_o), .rd_we_o(rd_we_o),
    .retire_cnt_o(retire_cnt_o)
  );

  wb_writeback #(.GPR_ADDR_SPACE(5), .GPR_WIDTH(32), .CNT_W(4)) dut_small (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_s),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .alu_val_i(alu_val_i),
    .is_load_i(is_load_i), .load_size_i(load_size_i), .load_unsigned_i(load_unsigned_i),
    .addr_lo_i(addr_lo_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .flush_i(flush_i), .rd_addr_o(rd_addr_s), .rd_val_o(rd_val_s), .rd_we_o(rd_we_s),
    .retire_cnt_o(retire_cnt_s)
  );

  typedef struct {
    int unsigned valid, rd_addr, rd_we, alu, is_load, size, uns, lo, rvalid, rdata, flush;
    int unsigned exp_ready, exp_we, exp_addr, exp_val, exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_i         = v.valid[0];
    rd_addr_i       = 5'(v.rd_addr);
    rd_we_i         = v.rd_we[0];
    alu_val_i       = v.alu;
    is_load_i       = v.is_load[0];
    load_size_i     = 2'(v.size);
    load_unsigned_i = v.uns[0];
    addr_lo_i       = 2'(v.lo);
    dmem_rvalid_i   = v.rvalid[0];
    dmem_rdata_i    = v.rdata;
    flush_i         = v.flush[0];
  endtask

  // Reference load formatting from the lane/extension rules.
  function automatic logic [31:0] fmt_load(input int unsigned rdata, input int unsigned size,
                                           input int unsigned uns, input int unsigned lo);
    int unsigned v;
    if (size == 0) begin
      v = (rdata >> (8 * lo)) & 32'hFF;
      if (uns == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rdata >> (16 * (lo / 2))) & 32'hFFFF;
      if (uns == 0 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Behavioural model state
  bit          m_busy;
  vec_t        m_pend;
  logic [31:0] m_addr, m_val, m_cnt;
  logic        m_we;

  task automatic model_step(input bit rst, input vec_t v);
    m_we = 1'b0;
    if (rst) begin
      m_busy = 0; m_addr = 0; m_val = 0; m_cnt = 0;
    end else if (v.flush != 0) begin
      m_busy = 0;
    end else if (!m_busy && v.valid != 0) begin
      if (v.is_load != 0) begin
        m_busy = 1; m_pend = v;
      end else begin
        m_cnt = m_cnt + 1;
        if (v.rd_we != 0 && v.rd_addr != 0) begin
          m_we = 1; m_addr = v.rd_addr; m_val = v.alu;
        end
      end
    end else if (m_busy && v.rvalid != 0) begin
      m_busy = 0;
      m_cnt = m_cnt + 1;
      if (m_pend.rd_we != 0 && m_pend.rd_addr != 0) begin
        m_we = 1; m_addr = m_pend.rd_addr;
        m_val = fmt_load(v.rdata, m_pend.size, m_pend.uns, m_pend.lo);
      end
    end
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    idle = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0};

    //            valid rd we alu           ld sz un lo rv rdata          fl  rdy we addr val          cnt
    vecs.push_back('{1, 5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,             0,  1, 1, 5, 32'hDEADBEEF, 1});
    vecs.push_back('{1, 6, 1, 32'h00000001, 0, 0, 0, 0, 0, 0,             0,  1, 1, 6, 32'h00000001, 2});
    vecs.push_back('{1, 7, 1, 0,            1, 0, 0, 3, 0, 0,             0,  1, 0, 0, 0,            2});
    vecs.push_back('{1, 7, 1, 0,            1, 0, 0, 3, 0, 0,             0,  0, 0, 0, 0,            2});
    vecs.push_back('{1, 7, 1, 0,            1, 0, 0, 3, 0, 0,             0,  0, 0, 0, 0,            2});
    vecs.push_back('{1, 7, 1, 0,            1, 0, 0, 3, 0, 0,             0,  0, 0, 0, 0,            2});
    vecs.push_back('{1, 7, 1, 0,            1, 0, 0, 3, 1, 32'h80123456,  0,  0, 1, 7, 32'hFFFFFF80, 3});
    vecs.push_back('{1, 8, 1, 0,            1, 1, 1, 2, 0, 0,             0,  1, 0, 0, 0,            3});
    vecs.push_back('{0, 0, 0, 0,            0, 0, 0, 0, 1, 32'h80123456,  0,  0, 1, 8, 32'h00008012, 4});
    vecs.push_back('{1, 0, 1, 32'h00000055, 0, 0, 0, 0, 0, 0,             0,  1, 0, 0, 0,            5});
    vecs.push_back('{1, 9, 1, 0,            1, 2, 0, 0, 0, 0,             0,  1, 0, 0, 0,            5});
    vecs.push_back('{0, 0, 0, 0,            0, 0, 0, 0, 1, 32'h12345678,  1,  0, 0, 0, 0,            5});
    vecs.push_back('{1, 10, 1, 32'h77,      0, 0, 0, 0, 0, 0,             1,  1, 0, 0, 0,            5});
    vecs.push_back('{0, 0, 0, 0,            0, 0, 0, 0, 1, 32'hCAFEF00D,  0,  1, 0, 0, 0,            5});
    vecs.push_back('{1, 11, 0, 32'h5,       0, 0, 0, 0, 0, 0,             0,  1, 0, 0, 0,            6});
    vecs.push_back('{1, 12, 1, 0,           1, 1, 0, 1, 0, 0,             0,  1, 0, 0, 0,            6});
    vecs.push_back('{0, 0, 0, 0,            0, 0, 0, 0, 1, 32'h1234F00D,  0,  0, 1, 12, 32'hFFFFF00D, 7});
    vecs.push_back('{1, 13, 1, 0,           1, 0, 1, 1, 0, 0,             0,  1, 0, 0, 0,            7});
    vecs.push_back('{0, 0, 0, 0,            0, 0, 0, 0, 1, 32'h0000AB00,  0,  0, 1, 13, 32'h000000AB, 8});
    vecs.push_back('{1, 14, 1, 0,           1, 3, 0, 2, 0, 0,             0,  1, 0, 0, 0,            8});
    vecs.push_back('{0, 0, 0, 0,            0, 0, 0, 0, 1, 32'h89ABCDEF,  0,  0, 1, 14, 32'h89ABCDEF, 9});

    // Reset for two cycles
    drive(idle);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("reset_we", {31'b0, rd_we_o}, 32'h0);
    check("reset_addr", {27'b0, rd_addr_o}, 32'h0);
    check("reset_val", rd_val_o, 32'h0);
    check("reset_cnt", retire_cnt_o, 32'h0);
    check("reset_ready", {31'b0, ready_o}, 32'h1);

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v);
      #1;
      check($sformatf("v%0d_ready", i), {31'b0, ready_o}, v.exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i), {31'b0, rd_we_o}, v.exp_we);
      if (v.exp_we != 0) begin
        check($sformatf("v%0d_addr", i), {27'b0, rd_addr_o}, v.exp_addr);
        check($sformatf("v%0d_val", i), rd_val_o, v.exp_val);
      end
      check($sformatf("v%0d_cnt", i), retire_cnt_o, v.exp_cnt);
      check($sformatf("v%0d_cnt4", i), {28'b0, retire_cnt_s}, v.exp_cnt & 32'hF);
      $display("vec %0d: we=%0b addr=%0d val=0x%08h cnt=%0d", i, rd_we_o, rd_addr_o, rd_val_o, retire_cnt_o);
    end

    // Reset asserted mid-WAIT with data arriving: pending load is dropped
    v = idle; v.valid = 1; v.rd_addr = 3; v.rd_we = 1; v.is_load = 1; v.size = 2;
    drive(v);
    @(posedge clk); #1;
    drive(idle);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hA5A5A5A5;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rstwait_we", {31'b0, rd_we_o}, 32'h0);
    check("rstwait_cnt", retire_cnt_o, 32'h0);
    check("rstwait_ready", {31'b0, ready_o}, 32'h1);
    @(posedge clk); #1;
    check("rstwait_we2", {31'b0, rd_we_o}, 32'h0);
    check("rstwait_cnt2", retire_cnt_o, 32'h0);
    $display("reset mid-wait: we=%0b cnt=%0d ready=%0b", rd_we_o, retire_cnt_o, ready_o);

    // Randomised traffic against the model
    m_busy = 0; m_addr = 0; m_val = 0; m_cnt = 0; m_we = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      v.valid   = ($urandom_range(0, 3) != 0);
      v.rd_addr = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31);
      v.rd_we   = ($urandom_range(0, 4) != 0);
      v.alu     = $urandom;
      v.is_load = $urandom_range(0, 1);
      v.size    = $urandom_range(0, 3);
      v.uns     = $urandom_range(0, 1);
      v.lo      = $urandom_range(0, 3);
      v.rvalid  = $urandom_range(0, 1);
      v.rdata   = $urandom;
      v.flush   = ($urandom_range(0, 9) == 0);
      drive(v);
      rst_i = r;
      #1;
      check("rnd_ready", {31'b0, ready_o}, {31'b0, !m_busy});
      model_step(r, v);
      @(posedge clk);
      #1;
      check("rnd_we", {31'b0, rd_we_o}, {31'b0, m_we});
      check("rnd_addr", {27'b0, rd_addr_o}, m_addr);
      check("rnd_val", rd_val_o, m_val);
      check("rnd_cnt", retire_cnt_o, m_cnt);
      check("rnd_cnt4", {28'b0, retire_cnt_s}, m_cnt & 32'hF);
      if (m_we) $display("rnd %0d: write x%0d = 0x%08h cnt=%0d", n, m_addr, m_val, m_cnt);
    end
    rst_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_writeback.md
Name: wb_writeback

Overview:
- Write-back stage: the write side of the general-purpose register file, whose read ports feed ID.
- Accepts retiring instructions from MEM through a valid/ready handshake.
- For loads, waits on the data-memory response, then aligns and sign/zero-extends the returned word.
- Drives a single registered write port (address, value, enable) into the register file. Also keeps a retired-instruction counter.

Parameters:
- GPR_ADDR_SPACE, 5, width of a register address (matches the `GPR_ADDR_SPACE` define).
- GPR_WIDTH, 32, register/data width (matches the `GPR_WIDTH` define).
- CNT_W, 32, width of the retire counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset: synchronous, active-high.
- valid_i  input  1  MEM presents an instruction.
- ready_o  output  1  stage can accept (combinational: 1 iff state==IDLE).
- rd_addr_i  input  GPR_ADDR_SPACE  destination register.
- rd_we_i  input  1  instruction writes rd.
- alu_val_i  input  GPR_WIDTH  result for non-loads.
- is_load_i  input  1  instruction is a load.
- load_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_i  input  1  zero-extend (LBU/LHU) when 1.
- addr_lo_i  input  2  load address bits [1:0].
- dmem_rvalid_i  input  1  load data valid.
- dmem_rdata_i  input  GPR_WIDTH  raw aligned memory word.
- flush_i  input  1  kill in-flight instruction.
- rd_addr_o  output  GPR_ADDR_SPACE  write address to regfile.
- rd_val_o  output  GPR_WIDTH  write data to regfile.
- rd_we_o  output  1  write enable to regfile (one-cycle pulse per write).
- retire_cnt_o  output  CNT_W  instructions retired.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rd_we_o=0, rd_val_o=0, rd_addr_o=0, retire_cnt_o=0. Reset overrides everything, including mid-WAIT; a pending load is dropped with no write.
- Handshake: transfer occurs on an edge with valid_i && ready_o. ready_o=0 in WAIT, so MEM holds its inputs.
- Outputs are registered. rd_we_o defaults to 0 every cycle unless set by the rules below.
- rd_we_o is never 1 with rd_addr_o==0: x0 writes are suppressed, but the instruction still retires.
- Non-load transfer in IDLE (flush_i=0):
  - Next edge sets rd_addr_o=rd_addr_i, rd_val_o=alu_val_i, rd_we_o=rd_we_i&&(rd_addr_i!=0).
  - retire_cnt_o increments. State stays IDLE.
  - Latency: write visible the cycle after transfer. Back-to-back transfers give back-to-back write pulses.
- Load transfer in IDLE (flush_i=0):
  - Latch rd_addr, rd_we, size, unsigned and addr_lo into pending registers. State goes to WAIT; rd_we_o=0.
- WAIT with dmem_rvalid_i=1 and flush_i=0:
  - Extract the load value:
    - byte: dmem_rdata_i[8*addr_lo+:8].
    - half: dmem_rdata_i[16*addr_lo[1]+:16]; addr_lo[0] is ignored.
    - word: the full word.
  - Sign-extend unless unsigned.
  - Set rd_val_o=extracted, rd_addr_o=pending addr, rd_we_o=pending we&&addr!=0.
  - retire_cnt_o increments. State goes to IDLE.
- WAIT with dmem_rvalid_i=0: hold; rd_we_o=0.
- dmem_rvalid_i in IDLE is ignored.
- flush_i=1:
  - In IDLE: no transfer occurs even if valid_i=1 (ready_o may read 1; the flush takes priority). No write, no count.
  - In WAIT: go to IDLE with no write and no count, even if dmem_rvalid_i=1 the same cycle.
- rd_addr_o and rd_val_o hold their last values when rd_we_o=0.
- retire_cnt_o wraps modulo 2^CNT_W.

Test Plan:
- Reset with rst_i=1 for 2 cycles → all outputs 0, ready_o=1; assert rst_i mid-WAIT → next cycle state IDLE, no rd_we_o pulse.
- Non-load rd=5, alu=0xDEADBEEF, we=1, then rd=6, alu=0x1 back-to-back → rd_we_o pulses on two consecutive cycles: (5,0xDEADBEEF), then (6,0x1); retire_cnt_o=2.
- Load byte signed, addr_lo=3, rdata=0x80123456; rvalid after 3 cycles → ready_o=0 for 3 cycles, then write 0xFFFFFF80. Repeat unsigned half, addr_lo=2 → 0x00008012.
- Write to x0 (rd=0, we=1, alu=0x55) → rd_we_o stays 0; retire_cnt_o increments by 1.
- Flush in WAIT coincident with dmem_rvalid_i=1 → no write, count unchanged, ready_o=1 next cycle. Flush in IDLE with valid_i=1 → nothing retired.
- Preload counter to 0xFFFFFFFF (via 2^32-1 forced retirements or hierarchical force), retire one more → retire_cnt_o=0.
